// File: rtl/reg_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// reg_transfer_sequencer
//
// Multi-cycle control sequencer for the R0-R7/B0 register file. One command
// is accepted at a time over CMD_VALID/CMD_READY. The block then steps through
// the execute states and drives the register-file write bus (S_BUS) and store
// enables (SR for R0-R7, SB0 for B0). ADD/SUB go through B0, which is the
// accumulator operand, so they overwrite B0 as a visible side effect.
//
// Optional feature macro: REGSEQ_SWAP_EN
//   defined   : opcode 101 (SWAP) executes in three cycles through B0 (EX3 exists)
//   undefined : opcode 101 is illegal (DONE+ERR, no writes) and EX3 is absent
//
// Ports
//   CLK        clock, rising edge
//   CLR        asynchronous active-high reset
//   CMD_VALID  command offered           CMD_READY  sequencer idle, can accept
//   CMD_OP     opcode                    CMD_RD/RS/RT register indices
//   CMD_IMM    LDI immediate
//   R_Q        packed R0..R7 from the register file (Ri at [WIDTH*i +: WIDTH])
//   B0_Q       B0 from the register file
//   S_BUS      write data to the register file
//   SR         one-hot store enable for R0..R7
//   SB0        store enable for B0
//   DONE       pulse in the final execute cycle
//   ERR        pulse with DONE for an illegal/disabled opcode
//   FLAG_C     carry (ADD) or borrow (SUB) of the last arithmetic command
// -----------------------------------------------------------------------------
module reg_transfer_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [2:0]                CMD_OP,
    input  logic [$clog2(NREG)-1:0]   CMD_RD,
    input  logic [$clog2(NREG)-1:0]   CMD_RS,
    input  logic [$clog2(NREG)-1:0]   CMD_RT,
    input  logic [WIDTH-1:0]          CMD_IMM,
    input  logic [WIDTH*NREG-1:0]     R_Q,
    input  logic [WIDTH-1:0]          B0_Q,
    output logic [WIDTH-1:0]          S_BUS,
    output logic [NREG-1:0]           SR,
    output logic                      SB0,
    output logic                      DONE,
    output logic                      ERR,
    output logic                      FLAG_C
);

    localparam int IDXW = $clog2(NREG);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
`ifdef REGSEQ_SWAP_EN
    localparam logic [2:0] OP_SWAP = 3'b101;
`endif

`ifdef REGSEQ_SWAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EX1 = 2'd1, EX2 = 2'd2, EX3 = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EX1 = 2'd1, EX2 = 2'd2} state_e;
`endif

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [IDXW-1:0]     rd_q, rs_q, rt_q;
    logic [WIDTH-1:0]    imm_q;
    logic                flag_c_q, flag_c_d;
    logic                accept_s;

    logic [WIDTH-1:0]    r_s [NREG];
    logic [WIDTH:0]      sum_s;
    logic [WIDTH:0]      diff_s;

    // One-hot store-enable decode of a register index.
    function automatic logic [NREG-1:0] dec_onehot(input logic [IDXW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Unpack the register file outputs into an indexable array.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            r_s[i] = R_Q[WIDTH*i +: WIDTH];
        end
    end

    // 17-bit unsigned arithmetic: bit WIDTH is carry for the sum and, because
    // the subtraction wraps modulo 2^17, it is set exactly when B0_Q < R[rt].
    always_comb begin
        sum_s  = {1'b0, B0_Q} + {1'b0, r_s[rt_q]};
        diff_s = {1'b0, B0_Q} - {1'b0, r_s[rt_q]};
    end

    assign CMD_READY = (state_q == IDLE) & ~CLR;
    assign FLAG_C    = flag_c_q;

    // Next-state and per-cycle output decode from the state and latched command.
    always_comb begin
        state_d  = state_q;
        flag_c_d = flag_c_q;
        accept_s = 1'b0;
        S_BUS    = '0;
        SR       = '0;
        SB0      = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    accept_s = 1'b1;
                    state_d  = EX1;
                end else begin
                    state_d  = IDLE;
                end
            end
            EX1: begin
                case (op_q)
                    OP_NOP: begin
                        DONE    = 1'b1;
                        state_d = IDLE;
                    end
                    OP_MOV: begin
                        S_BUS   = r_s[rs_q];
                        SR      = dec_onehot(rd_q);
                        DONE    = 1'b1;
                        state_d = IDLE;
                    end
                    OP_LDI: begin
                        S_BUS   = imm_q;
                        SR      = dec_onehot(rd_q);
                        DONE    = 1'b1;
                        state_d = IDLE;
                    end
                    OP_ADD, OP_SUB: begin
                        // first operand is parked in B0 for the EX2 add/sub
                        S_BUS   = r_s[rs_q];
                        SB0     = 1'b1;
                        state_d = EX2;
                    end
`ifdef REGSEQ_SWAP_EN
                    OP_SWAP: begin
                        S_BUS   = r_s[rd_q];
                        SB0     = 1'b1;
                        state_d = EX2;
                    end
`endif
                    default: begin
                        DONE    = 1'b1;
                        ERR     = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            EX2: begin
                case (op_q)
                    OP_ADD: begin
                        S_BUS    = sum_s[WIDTH-1:0];
                        SR       = dec_onehot(rd_q);
                        DONE     = 1'b1;
                        flag_c_d = sum_s[WIDTH];
                        state_d  = IDLE;
                    end
                    OP_SUB: begin
                        S_BUS    = diff_s[WIDTH-1:0];
                        SR       = dec_onehot(rd_q);
                        DONE     = 1'b1;
                        flag_c_d = diff_s[WIDTH];
                        state_d  = IDLE;
                    end
`ifdef REGSEQ_SWAP_EN
                    OP_SWAP: begin
                        S_BUS   = r_s[rs_q];
                        SR      = dec_onehot(rd_q);
                        state_d = EX3;
                    end
`endif
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
`ifdef REGSEQ_SWAP_EN
            EX3: begin
                // B0 holds the original R[rd] saved in EX1
                S_BUS   = B0_Q;
                SR      = dec_onehot(rs_q);
                DONE    = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and carry flag.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flag_c_q <= flag_c_d;
        end
    end

    // Command latch, loaded only on an accepted handshake in IDLE.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            op_q  <= 3'b000;
            rd_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            imm_q <= '0;
        end else if (accept_s) begin
            op_q  <= CMD_OP;
            rd_q  <= CMD_RD;
            rs_q  <= CMD_RS;
            rt_q  <= CMD_RT;
            imm_q <= CMD_IMM;
        end else begin
            op_q  <= op_q;
            rd_q  <= rd_q;
            rs_q  <= rs_q;
            rt_q  <= rt_q;
            imm_q <= imm_q;
        end
    end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_transfer_sequencer
//
// Bench for reg_transfer_sequencer with a behavioural register file closing
// the R_Q/B0_Q feedback loop. A table of commands with hand-derived final-cycle
// results is pushed to a scoreboard queue on accept and popped when DONE
// appears. Hand-written sequences cover reset, mid-command reset, command
// inputs changing while busy, and back-to-back accept.
// -----------------------------------------------------------------------------
module tb_reg_transfer_sequencer;

    logic         CLK = 1'b0;
    logic         CLR = 1'b1;
    logic         CMD_VALID = 1'b0;
    logic         CMD_READY;
    logic [2:0]   CMD_OP = 3'd0, CMD_RD = 3'd0, CMD_RS = 3'd0, CMD_RT = 3'd0;
    logic [15:0]  CMD_IMM = 16'h0;
    logic [127:0] R_Q;
    logic [15:0]  B0_Q;
    logic [15:0]  S_BUS;
    logic [7:0]   SR;
    logic         SB0, DONE, ERR, FLAG_C;

    logic [15:0]  rf [8];
    logic [15:0]  b0_rf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [2:0]  op, rd, rs, rt;
        logic [15:0] imm;
        int          lat;
        logic [15:0] bus;
        logic [7:0]  sr;
        logic        err;
        logic        fc;
    } vec_t;

    vec_t vecs [$];
    vec_t exp_q [$];

    reg_transfer_sequencer #(.WIDTH(16), .NREG(8)) dut (
        .CLK(CLK), .CLR(CLR),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_RD(CMD_RD), .CMD_RS(CMD_RS), .CMD_RT(CMD_RT),
        .CMD_IMM(CMD_IMM),
        .R_Q(R_Q), .B0_Q(B0_Q),
        .S_BUS(S_BUS), .SR(SR), .SB0(SB0),
        .DONE(DONE), .ERR(ERR), .FLAG_C(FLAG_C)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file (not cleared by CLR).
    always @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (SR[i]) rf[i] <= S_BUS;
        end
        if (SB0) b0_rf <= S_BUS;
    end

    always_comb begin
        R_Q = '0;
        for (int i = 0; i < 8; i++) R_Q[16*i +: 16] = rf[i];
        B0_Q = b0_rf;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [2:0] op, rd, rs, rt,
                           input logic [15:0] imm, input int lat,
                           input logic [15:0] bus, input logic [7:0] sr,
                           input logic err, input logic fc);
        vec_t v;
        v.name = nm; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
        v.lat = lat; v.bus = bus; v.sr = sr; v.err = err; v.fc = fc;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for CMD_READY at a falling edge, then offer one command.
    task automatic drive_cmd(input logic [2:0] op, rd, rs, rt, input logic [15:0] imm);
        int w;
        w = 0;
        while (CMD_READY !== 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_wait", {31'd0, CMD_READY}, 32'd1);
        CMD_OP = op; CMD_RD = rd; CMD_RS = rs; CMD_RT = rt; CMD_IMM = imm;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   cyc;
        bit   got;
        drive_cmd(v.op, v.rd, v.rs, v.rt, v.imm);
        exp_q.push_back(v);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 6) begin
            @(negedge CLK);
            cyc++;
            if (DONE === 1'b1) begin
                got = 1'b1;
                e = exp_q.pop_front();
                chk({e.name, ".lat"}, cyc, e.lat);
                chk({e.name, ".bus"}, {16'd0, S_BUS}, {16'd0, e.bus});
                chk({e.name, ".sr"},  {24'd0, SR}, {24'd0, e.sr});
                chk({e.name, ".sb0"}, {31'd0, SB0}, 32'd0);
                chk({e.name, ".err"}, {31'd0, ERR}, {31'd0, e.err});
            end else begin
                chk({v.name, ".busy_err"}, {31'd0, ERR}, 32'd0);
            end
        end
        if (!got) begin
            chk({v.name, ".done_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end
        @(negedge CLK);
        chk({v.name, ".ready_after"}, {31'd0, CMD_READY}, 32'd1);
        chk({v.name, ".done_pulse"},  {31'd0, DONE}, 32'd0);
        chk({v.name, ".flag_c"},      {31'd0, FLAG_C}, {31'd0, v.fc});
    endtask

    initial begin
        // Table: final-cycle expectations derived by hand from the command order.
        add_vec("ldi_r3",   3'd2, 3'd3, 3'd0, 3'd0, 16'h1234, 1, 16'h1234, 8'h08, 1'b0, 1'b0);
        add_vec("ldi_r2",   3'd2, 3'd2, 3'd0, 3'd0, 16'h00FF, 1, 16'h00FF, 8'h04, 1'b0, 1'b0);
        add_vec("mov_r5",   3'd1, 3'd5, 3'd2, 3'd0, 16'h0000, 1, 16'h00FF, 8'h20, 1'b0, 1'b0);
        add_vec("ldi_r1",   3'd2, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1, 16'hFFFF, 8'h02, 1'b0, 1'b0);
        add_vec("ldi_r4",   3'd2, 3'd4, 3'd0, 3'd0, 16'h0002, 1, 16'h0002, 8'h10, 1'b0, 1'b0);
        add_vec("add_c",    3'd3, 3'd0, 3'd1, 3'd4, 16'h0000, 2, 16'h0001, 8'h01, 1'b0, 1'b1);
        add_vec("sub_b",    3'd4, 3'd0, 3'd4, 3'd1, 16'h0000, 2, 16'h0003, 8'h01, 1'b0, 1'b1);
        add_vec("ldi_r6",   3'd2, 3'd6, 3'd0, 3'd0, 16'hAAAA, 1, 16'hAAAA, 8'h40, 1'b0, 1'b1);
        add_vec("ldi_r7",   3'd2, 3'd7, 3'd0, 3'd0, 16'h5555, 1, 16'h5555, 8'h80, 1'b0, 1'b1);
`ifdef REGSEQ_SWAP_EN
        add_vec("swap",     3'd5, 3'd6, 3'd7, 3'd0, 16'h0000, 3, 16'hAAAA, 8'h80, 1'b0, 1'b1);
        add_vec("mov_r6",   3'd1, 3'd0, 3'd6, 3'd0, 16'h0000, 1, 16'h5555, 8'h01, 1'b0, 1'b1);
`else
        add_vec("swap_ill", 3'd5, 3'd6, 3'd7, 3'd0, 16'h0000, 1, 16'h0000, 8'h00, 1'b1, 1'b1);
        add_vec("mov_r6",   3'd1, 3'd0, 3'd6, 3'd0, 16'h0000, 1, 16'hAAAA, 8'h01, 1'b0, 1'b1);
`endif
        add_vec("add_nc",   3'd3, 3'd2, 3'd2, 3'd3, 16'h0000, 2, 16'h1333, 8'h04, 1'b0, 1'b0);
        add_vec("ill_111",  3'd7, 3'd1, 3'd2, 3'd3, 16'hFFFF, 1, 16'h0000, 8'h00, 1'b1, 1'b0);
        add_vec("ill_110",  3'd6, 3'd4, 3'd4, 3'd4, 16'h1111, 1, 16'h0000, 8'h00, 1'b1, 1'b0);
        add_vec("nop",      3'd0, 3'd7, 3'd7, 3'd7, 16'hBEEF, 1, 16'h0000, 8'h00, 1'b0, 1'b0);
        add_vec("sub_wrap", 3'd4, 3'd1, 3'd3, 3'd2, 16'h0000, 2, 16'hFF01, 8'h02, 1'b0, 1'b1);
        add_vec("sub_self", 3'd4, 3'd5, 3'd3, 3'd3, 16'h0000, 2, 16'h0000, 8'h20, 1'b0, 1'b0);
        add_vec("add_alias",3'd3, 3'd1, 3'd1, 3'd1, 16'h0000, 2, 16'hFE02, 8'h02, 1'b0, 1'b1);

        // Reset state while CLR is held.
        @(negedge CLK);
        chk("rst.ready", {31'd0, CMD_READY}, 32'd0);
        chk("rst.bus",   {16'd0, S_BUS}, 32'd0);
        chk("rst.sr",    {24'd0, SR}, 32'd0);
        chk("rst.sb0",   {31'd0, SB0}, 32'd0);
        chk("rst.done",  {31'd0, DONE}, 32'd0);
        chk("rst.err",   {31'd0, ERR}, 32'd0);
        chk("rst.flag_c",{31'd0, FLAG_C}, 32'd0);
        CMD_VALID = 1'b1;               // held while not ready: must be ignored
        @(negedge CLK);
        chk("rst.ready_hold", {31'd0, CMD_READY}, 32'd0);
        CMD_VALID = 1'b0;
        CLR = 1'b0;
        #1;
        chk("rst.ready_release", {31'd0, CMD_READY}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during EX2 of ADD R0 <- R4 + R1 (R4=0002, R1=FE02, FLAG_C=1).
        drive_cmd(3'd3, 3'd0, 3'd4, 3'd1, 16'h0000);
        @(negedge CLK);
        chk("mid.ex1_bus", {16'd0, S_BUS}, 32'h0002);
        chk("mid.ex1_sb0", {31'd0, SB0}, 32'd1);
        chk("mid.ex1_sr",  {24'd0, SR}, 32'd0);
        @(negedge CLK);
        chk("mid.ex2_done", {31'd0, DONE}, 32'd1);
        chk("mid.ex2_bus",  {16'd0, S_BUS}, 32'hFE04);
        #1;
        CLR = 1'b1;
        #1;
        chk("mid.bus",    {16'd0, S_BUS}, 32'd0);
        chk("mid.sr",     {24'd0, SR}, 32'd0);
        chk("mid.sb0",    {31'd0, SB0}, 32'd0);
        chk("mid.done",   {31'd0, DONE}, 32'd0);
        chk("mid.ready",  {31'd0, CMD_READY}, 32'd0);
        chk("mid.flag_c", {31'd0, FLAG_C}, 32'd0);
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        chk("mid.ready_after", {31'd0, CMD_READY}, 32'd1);
        chk("mid.b0_kept",     {16'd0, b0_rf}, 32'h0002);
`ifdef REGSEQ_SWAP_EN
        chk("mid.r0_kept",     {16'd0, rf[0]}, 32'h5555);
`else
        chk("mid.r0_kept",     {16'd0, rf[0]}, 32'hAAAA);
`endif

        // Inputs change while busy, then back-to-back accept of the held LDI.
        drive_cmd(3'd3, 3'd5, 3'd4, 3'd4, 16'h0000);
        CMD_VALID = 1'b1;
        CMD_OP = 3'd2; CMD_RD = 3'd7; CMD_RS = 3'd0; CMD_RT = 3'd0; CMD_IMM = 16'hDEAD;
        @(negedge CLK);
        chk("hold.ex1_bus", {16'd0, S_BUS}, 32'h0002);
        chk("hold.ex1_sb0", {31'd0, SB0}, 32'd1);
        chk("hold.ex1_done",{31'd0, DONE}, 32'd0);
        @(negedge CLK);
        chk("hold.ex2_bus", {16'd0, S_BUS}, 32'h0004);
        chk("hold.ex2_sr",  {24'd0, SR}, 32'h20);
        chk("hold.ex2_done",{31'd0, DONE}, 32'd1);
        @(negedge CLK);
        chk("hold.idle_ready", {31'd0, CMD_READY}, 32'd1);
        chk("hold.flag_c",     {31'd0, FLAG_C}, 32'd0);
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b.bus",  {16'd0, S_BUS}, 32'hDEAD);
        chk("b2b.sr",   {24'd0, SR}, 32'h80);
        chk("b2b.done", {31'd0, DONE}, 32'd1);
        @(negedge CLK);
        chk("b2b.r5",   {16'd0, rf[5]}, 32'h0004);
        chk("b2b.r7",   {16'd0, rf[7]}, 32'hDEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_transfer_sequencer.md
# reg_transfer_sequencer

Multi-cycle control sequencer that drives the R0–R7/B0 register file. It accepts one register-transfer command at a time over a valid/ready handshake and generates the S_BUS value and the SR/SB0 store enables cycle by cycle. It contains the 16-bit add/subtract path, which uses B0 as the accumulator operand. It sits between the instruction decoder and the register file. The register file's R0–R7 and B0 outputs feed back into this block.

## Interface
Parameters:
- WIDTH, 16, datapath width (register file width)
- NREG, 8, number of general registers; register index width is 3

Ports:
- CLK  in  1  clock, all state updates on rising edge
- CLR  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  sequencer can accept a command
- CMD_OP  in  3  opcode: 000 NOP, 001 MOV, 010 LDI, 011 ADD, 100 SUB, 101 SWAP, 110/111 illegal
- CMD_RD  in  3  destination register index
- CMD_RS  in  3  source register index
- CMD_RT  in  3  second operand register index (ADD/SUB)
- CMD_IMM  in  16  immediate value (LDI)
- R_Q  in  128  register file outputs; R_Q[16*i+15:16*i] is Ri
- B0_Q  in  16  B0 output
- S_BUS  out  16  data bus to register file
- SR  out  8  store enables for R0–R7
- SB0  out  1  store enable for B0
- DONE  out  1  one-cycle pulse in the final cycle of a command
- ERR  out  1  one-cycle pulse with DONE for an illegal or disabled opcode
- FLAG_C  out  1  carry/borrow from the last ADD/SUB

## Operation
- Sequencing: FSM with states IDLE, EX1, EX2, EX3.
  - CMD_READY = (state==IDLE) & ~CLR.
  - On CMD_VALID & CMD_READY at a clock edge, the sequencer latches op, rd, rs, rt and imm, then moves to EX1.
- Outputs: S_BUS, SR, SB0, DONE and ERR decode combinationally from the state and the latched command only. There is no combinational path from CMD_* to any output.
- Default values: any cycle without a write drives S_BUS=0, SR=0, SB0=0.
- Per-cycle behaviour by opcode:
  - NOP: EX1 drives no enables and asserts DONE, then returns to IDLE.
  - MOV: EX1 drives S_BUS=R[rs], SR=1<<rd and DONE, then returns to IDLE.
  - LDI: EX1 drives S_BUS=imm, SR=1<<rd and DONE, then returns to IDLE.
  - ADD: EX1 drives S_BUS=R[rs] and SB0=1. EX2 drives S_BUS=(B0_Q+R[rt])[15:0], SR=1<<rd and DONE. FLAG_C takes the carry out at the end of EX2.
  - SUB: same as ADD, but EX2 drives S_BUS=B0_Q−R[rt] mod 2^16. FLAG_C=1 iff B0_Q<R[rt] (unsigned borrow).
  - SWAP: EX1 drives S_BUS=R[rd] and SB0=1. EX2 drives S_BUS=R[rs] and SR=1<<rd. EX3 drives S_BUS=B0_Q, SR=1<<rs and DONE.
  - Illegal (110/111): EX1 drives no enables and asserts DONE and ERR, then returns to IDLE.
- Width rules: the arithmetic is unsigned 17-bit internally, and S_BUS carries the low 16 bits.
- Side effects: ADD, SUB and SWAP overwrite B0; this is architecturally visible. FLAG_C is unchanged by all other opcodes.
- Aliasing: rd/rs/rt may alias. ADD R1,R1,R1 yields 2·R1. SWAP with rd==rs takes 3 cycles and leaves the value unchanged.
- At most one bit of SR is set in any cycle. SB0 and SR are never set together.

## Timing
- Latency from the accept edge to the edge that commits the final write: MOV/LDI/NOP/illegal 1 cycle, ADD/SUB 2, SWAP 3.
- DONE is high during the final execute cycle; that cycle's write commits at the edge ending it.
- CMD_READY returns high the cycle after DONE, so throughput is one command per (latency+1) cycles. Back-to-back accept is possible on the first IDLE cycle.
- Reset values: state=IDLE, S_BUS=0, SR=0, SB0=0, DONE=0, ERR=0, FLAG_C=0, CMD_READY=0 while CLR is high.
- Reset mid-command: the FSM returns to IDLE immediately and the command is abandoned with no DONE. Writes committed on earlier edges stand.
- CMD_VALID held high while not ready: no effect; the command is sampled only in IDLE.

## Configuration
- Macro REGSEQ_SWAP_EN:
  - Defined: the SWAP opcode (101) is executed as described, and the EX3 state exists.
  - Undefined: 101 is treated as illegal (1-cycle DONE+ERR, no writes), and EX3 is removed from the FSM.

## Test plan
- Reset, then LDI R3,0x1234 → 1 cycle after accept: SR=0x08, S_BUS=0x1234, DONE=1; next cycle CMD_READY=1.
- R2=0x00FF, MOV R5←R2 → EX1: SR=0x20, S_BUS=0x00FF, SB0=0.
- R1=0xFFFF, R4=0x0002, ADD R0←R1+R4 → EX1: SB0=1, S_BUS=0xFFFF; EX2: SR=0x01, S_BUS=0x0001; FLAG_C=1. Then SUB R0←R4−R1 with R4=0x0002 → S_BUS=0x0003, FLAG_C=1.
- R6=0xAAAA, R7=0x5555, SWAP R6,R7 → with REGSEQ_SWAP_EN: R6=0x5555, R7=0xAAAA and B0=0xAAAA after 3 cycles. Without the macro: DONE+ERR in EX1, no SR/SB0 activity.
- Opcode 111 → DONE=1 and ERR=1 for one cycle; SR=0, SB0=0, FLAG_C unchanged.
- Assert CLR during EX2 of ADD → SR/SB0/S_BUS=0 immediately, no DONE, B0 keeps its EX1 value; after release, CMD_READY=1.
